// File: rtl/multi_clock_divider.sv
// Multi-channel glitch-free clock divider with per-channel enable, tick strobe and shared sync.
// A channel adopts a new divisor only at a period boundary; divisors 0 and 1 both bypass.
module multi_clock_divider #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4
) (
  input  logic                      clock_in,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] divisor,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clock_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS*WIDTH-1:0] active_divisor
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][WIDTH-1:0] act_q, act_d;
  logic [CHANNELS-1:0]            run_q, run_d;
  logic [CHANNELS-1:0]            byp_q, byp_d;
  logic [CHANNELS-1:0]            clk_q, clk_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;

  always_comb begin
    cnt_d  = '0;
    act_d  = '0;
    run_d  = '0;
    byp_d  = '0;
    clk_d  = '0;
    tick_d = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      run_d[i] = enable[i];
      act_d[i] = divisor[i*WIDTH +: WIDTH];
      if (!enable[i]) begin
        cnt_d[i] = '0;
      end else if (!run_q[i] || sync || act_q[i] <= One) begin
        // Start, resync, or leaving bypass: restart at phase 0 with a fresh divisor.
        cnt_d[i] = '0;
      end else if (cnt_q[i] == act_q[i] - One) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + One;
        act_d[i] = act_q[i];
      end
      byp_d[i]  = enable[i] & (act_d[i] <= One);
      tick_d[i] = enable[i] & (cnt_d[i] == '0);
      clk_d[i]  = enable[i] & ~byp_d[i] & (cnt_d[i] >= (act_d[i] >> 1));
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt_q  <= '0;
      act_q  <= '0;
      run_q  <= '0;
      byp_q  <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      run_q  <= run_d;
      byp_q  <= byp_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  // Bypass passes the source clock through, gated only by registered state.
  assign clock_out      = (run_q & byp_q & {CHANNELS{clock_in}}) | clk_q;
  assign tick           = tick_q;
  assign active_divisor = act_q;

endmodule

// File: doc/multi_clock_divider.md
# multi_clock_divider

Parametrised multi-channel clock divider, the successor to the single-channel divider. It generates CHANNELS independent divided clocks from one source clock. Each channel has its own divisor, an enable, and a per-period tick strobe. Divisor changes take effect only at period boundaries, so the divided outputs are glitch-free, and a shared sync pulse phase-aligns all channels. It sits between the system clock and the ADS1299 sampling and stimulus-timing logic.

## Interface
- WIDTH, 16: bit width of each divisor and of each channel counter.
- CHANNELS, 4: number of independent divider channels (1..16).
- clock_in  input  1  source clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- divisor  input  CHANNELS*WIDTH  channel i divisor in bits [i*WIDTH +: WIDTH]; unsigned.
- enable  input  CHANNELS  per-channel run enable.
- sync  input  1  one-cycle pulse; restarts all enabled channels at phase 0.
- clock_out  output  CHANNELS  divided clocks.
- tick  output  CHANNELS  one-cycle strobe in the first cycle of each output period.
- active_divisor  output  CHANNELS*WIDTH  divisor currently in effect per channel (status).

## Operation
- Per-channel state: counter[WIDTH], act_div[WIDTH] (exported as active_divisor), and registered clock_out and tick.
- Update priority, highest first: reset > enable low > sync > normal count.
- reset: every counter = 0, act_div = 0, clock_out = 0, tick = 0.
- enable[i] low (idle):
  - counter = 0, clock_out[i] = 0, tick[i] = 0.
  - act_div loads divisor[i] every cycle.
- sync high with enable[i] high:
  - act_div <= divisor[i], counter <= 0.
  - tick[i] = 1 next cycle; clock_out[i] = 0 next cycle (or clock_in if bypass).
- Normal count, act_div = N >= 2:
  - counter <= (counter == N-1) ? 0 : counter + 1.
  - When counter wraps (counter == N-1), act_div <= divisor[i]. This is the only point where a running channel adopts a new divisor.
  - clock_out and tick are registered from the next-state counter and the next-state act_div, so they are aligned with counter:
    - clock_out[i] = (counter >= N>>1).
    - tick[i] = (counter == 0).
  - Resulting waveform: low for floor(N/2) cycles, high for N - floor(N/2) cycles, period exactly N. Odd N gives the extra cycle to the high phase.
- Bypass, act_div <= 1 (0 and 1 both mean divide-by-1):
  - clock_out[i] = clock_in (combinational mux, gated by the registered bypass/enable state).
  - tick[i] = 1 every cycle, counter held at 0.
  - A new divisor is adopted every cycle while in bypass.
- Width rules:
  - Comparisons are unsigned at WIDTH bits.
  - N-1 is never computed when N <= 1 (bypass path).
  - Max N = 2^WIDTH - 1; divisor = all-ones is legal.
- Channels are fully independent except for the shared sync and reset.

## Timing
- Enable rising at edge E with divisor N >= 2: counter = 0, tick = 1, clock_out = 0 in cycle E+1. The first rising edge of clock_out is in cycle E+1+floor(N/2).
- Divisor change mid-period: the current period finishes at the old N. The new value sampled at the wrap edge applies from the next tick. Values presented and withdrawn before the wrap are ignored.
- sync latency: 1 cycle. All enabled channels show tick = 1 in the same cycle.
- sync coinciding with a natural wrap: result is identical (counter 0, tick 1).
- Enable dropping mid-period: outputs go to 0 on the next edge, with no partial-period completion.
- reset mid-operation: all outputs are 0 on the next edge. After reset releases, channels with enable high restart exactly as on an enable rising edge.
- Transition bypass to N >= 2: occurs on the next edge, with counter = 0 and tick = 1.
- Transition N >= 2 to bypass: occurs only at a wrap.

## Test plan
- CHANNELS=2, ch0 N=4, ch1 N=5, enable both after reset:
  - ch0 clock_out repeats 0,0,1,1.
  - ch1 clock_out repeats 0,0,1,1,1.
  - ticks every 4 and every 5 cycles respectively.
- ch0 running N=4, switch divisor to 6 at counter=1: the period completes at 4 cycles, then 0,0,0,1,1,1 repeats; active_divisor changes exactly at the tick.
- ch0 N=8, ch1 N=8 offset by 3 cycles, pulse sync: next cycle both show tick = 1 and counter = 0, and they stay identical thereafter.
- divisor = 1 and then divisor = 0 on ch0: clock_out follows clock_in and tick is high every cycle. Changing to N=2 yields 0,1 repeating from the next edge.
- reset asserted mid-period with N=6: the next cycle has all clock_out = 0, tick = 0, active_divisor = 0. After release, the first tick comes 1 cycle later.
- Divisor = 0xFFFF (WIDTH=16), checked over 2 periods: low 32767 cycles, high 32768 cycles, no counter overflow.
